vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480 @ 60 Hz VGA raster timing from the system clock.
- Produces pixel strobe, DrawX/DrawY counters, active-high visible flag `blank`, and active-low `hs`/`vs` syncs.
- Acts as the producer end of the raster interface: the color mapper consumes DrawX/DrawY/blank and returns RGB; the sync outputs drive the DAC/connector.
- Also supplies `frame_start`/`vblank` so game logic (tank motion, bullets) updates once per frame, outside the visible region.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, CLK cycles per pixel; even, ≥2

Ports:
- CLK  in  1  single clock for the whole block
- Reset_n  in  1  asynchronous, active-low reset
- pixel_clk  out  1  divided clock for the DAC; high for the second half of each pixel period
- pix_en  out  1  one-CLK strobe, once per pixel period
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = visible pixel, 0 = blanking
- sync  out  1  constant 0 (composite sync unused)
- DrawX  out  10  horizontal counter
- DrawY  out  10  vertical counter
- frame_start  out  1  one-CLK pulse at frame wrap
- vblank  out  1  1 while DrawY ≥ V_VISIBLE

## Operation
- Totals: H_TOTAL = sum of horizontal parameters (800); V_TOTAL = sum of vertical parameters (525).
- div_cnt:
  - counts 0..CLK_DIV-1, then wraps.
  - pix_en = (div_cnt == CLK_DIV-1).
  - pixel_clk = (div_cnt ≥ CLK_DIV/2), registered.
- Horizontal counter hc (drives DrawX):
  - advances only on pix_en.
  - at H_TOTAL-1 it wraps to 0.
- Vertical counter vc (drives DrawY):
  - advances only on pix_en when hc wraps.
  - at V_TOTAL-1 it wraps to 0.
- Outputs are registered decodes of the next counter values, so they change in the same CLK edge as DrawX/DrawY:
  - hs = 0 iff H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs = 0 iff V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - vblank = (vc ≥ V_VISIBLE).
- DrawX/DrawY expose the full counter range (0..799, 0..524). Consumers must gate on blank.
- frame_start pulses for exactly one CLK, on the edge where (hc,vc) goes (799,524)→(0,0).
- No frame_start is issued on reset release.
- All arithmetic is unsigned 10-bit. Counters never exceed TOTAL-1.

## Timing
- Reset values (async, while Reset_n = 0):
  - div_cnt = 0, hc = 0, vc = 0, DrawX = 0, DrawY = 0
  - pixel_clk = 0, pix_en = 0, hs = 1, vs = 1
  - blank = 0, vblank = 0, frame_start = 0, sync = 0
- Deassertion: first pix_en occurs CLK_DIV cycles after Reset_n rises.
- blank stays 0 until the first pix_en; pixel (0,0) of the first frame after reset is therefore dark.
- Latency: 0 CLK from a counter update to the matching hs/vs/blank/vblank update (same edge).
- Line period = H_TOTAL·CLK_DIV CLK (1600). Frame period = 1600·525 = 840000 CLK.
- Simultaneous H and V wrap: vc and hc update on the same edge, and frame_start fires on that edge.
- Reset mid-frame: all state returns immediately to reset values. The frame restarts from (0,0) with no partial sync pulse extension.

## Configuration
- `VGA_PIPE_ALIGN_EN` defined:
  - hs, vs and blank pass through one extra register stage that loads on pix_en.
  - This delays them by one pixel period, matching the color mapper's registered RGB output.
  - The delay-stage reset values are hs = 1, vs = 1, blank = 0.
  - DrawX, DrawY, vblank and frame_start are not delayed.
- `VGA_PIPE_ALIGN_EN` undefined: hs/vs/blank align with DrawX/DrawY exactly as in Operation.

## Test plan
- Reset: hold Reset_n = 0 for 5 CLK.
  - Required: DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, frame_start = 0.
  - After release, first pix_en arrives on CLK 2; DrawX then reads 1.
- Horizontal timing, one line:
  - hs low for exactly 96 pixels: 192 CLK, DrawX 656..751.
  - blank high for DrawX 0..639 on DrawY 0; low for DrawX 640..799.
- Vertical timing:
  - vs low only for DrawY 490 and 491, i.e. 1600 pixels.
  - vblank = 1 for DrawY 480..524.
  - blank = 0 for the whole of line 480.
- Frame wrap:
  - at (799,524), the next pix_en gives (0,0) and frame_start = 1 for one CLK.
  - successive frame_start pulses are exactly 840000 CLK apart.
- Mid-frame reset: pulse Reset_n low at (300,200) for one CLK.
  - outputs go to reset values asynchronously;
  - counting restarts at (0,0); no frame_start is issued.
- With `VGA_PIPE_ALIGN_EN`:
  - hs falls one pixel period (2 CLK) after DrawX becomes 656;
  - blank falls when DrawX = 641.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for 640x480 @ 60 Hz VGA (parameterisable).
//   It divides the system clock down to a pixel rate and produces the pixel
//   strobe, the DrawX/DrawY scan counters, the active-low sync pulses, the
//   visible-pixel flag and the once-per-frame markers used by game logic.
//
// Ports:
//   CLK          in   system clock, the only clock of this block
//   Reset_n      in   asynchronous active-low reset
//   pixel_clk    out  divided clock for the DAC, high in the 2nd half of a pixel
//   pix_en       out  one-CLK strobe, high in the CLK after each counter update
//   hs / vs      out  horizontal / vertical sync, active low
//   blank        out  1 = visible pixel, 0 = blanking
//   sync         out  composite sync, tied to 0
//   DrawX/DrawY  out  10-bit horizontal / vertical scan counters (full range)
//   frame_start  out  one-CLK pulse on the (H_TOTAL-1,V_TOTAL-1)->(0,0) edge
//   vblank       out  1 while DrawY >= V_VISIBLE
//
// Build option:
//   VGA_PIPE_ALIGN_EN - when defined, hs/vs/blank are delayed by one pixel
//   period so they line up with a colour mapper that registers its RGB.
//   DrawX, DrawY, vblank and frame_start are never delayed.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       CLK,
  input  logic       Reset_n,
  output logic       pixel_clk,
  output logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [9:0]       hc_reg, hc_next;
  logic [9:0]       vc_reg, vc_next;
  logic             tick;
  logic             h_wrap, v_wrap;
  logic             hs_next, vs_next, blank_next, vblank_next;

  logic pixel_clk_reg, pix_en_reg, frame_start_reg;
  logic hs_reg, vs_reg, blank_reg, vblank_reg;

  // Next-state counters. The sync/blank decodes are taken from the next
  // values so the registered flags change on the same edge as DrawX/DrawY.
  always_comb begin
    tick         = (div_cnt_reg == DIV_LAST);
    div_cnt_next = tick ? '0 : div_cnt_reg + DIV_ONE;
    h_wrap       = (hc_reg == H_LAST);
    v_wrap       = (vc_reg == V_LAST);
    hc_next      = hc_reg;
    vc_next      = vc_reg;
    if (tick) begin
      hc_next = h_wrap ? 10'd0 : hc_reg + 10'd1;
      if (h_wrap) begin
        vc_next = v_wrap ? 10'd0 : vc_reg + 10'd1;
      end
    end
    hs_next     = !((hc_next >= HS_START) && (hc_next < HS_END));
    vs_next     = !((vc_next >= VS_START) && (vc_next < VS_END));
    blank_next  = (hc_next < H_VIS) && (vc_next < V_VIS);
    vblank_next = (vc_next >= V_VIS);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_reg     <= '0;
      hc_reg          <= 10'd0;
      vc_reg          <= 10'd0;
      pixel_clk_reg   <= 1'b0;
      pix_en_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_reg       <= 1'b0;
      vblank_reg      <= 1'b0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      pix_en_reg      <= tick;
      pixel_clk_reg   <= (div_cnt_next >= DIV_HALF);
      frame_start_reg <= tick && h_wrap && v_wrap;
      // Flags only load on a pixel step, so blank stays low after reset
      // until the first pixel step (pixel 0,0 of that frame is dark).
      if (tick) begin
        hc_reg     <= hc_next;
        vc_reg     <= vc_next;
        hs_reg     <= hs_next;
        vs_reg     <= vs_next;
        blank_reg  <= blank_next;
        vblank_reg <= vblank_next;
      end
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_pipe_reg, vs_pipe_reg, blank_pipe_reg;

  // One pixel period of delay: each pixel step captures the flags that
  // belonged to the previous pixel.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_pipe_reg    <= 1'b1;
      vs_pipe_reg    <= 1'b1;
      blank_pipe_reg <= 1'b0;
    end else if (tick) begin
      hs_pipe_reg    <= hs_reg;
      vs_pipe_reg    <= vs_reg;
      blank_pipe_reg <= blank_reg;
    end
  end

  assign hs    = hs_pipe_reg;
  assign vs    = vs_pipe_reg;
  assign blank = blank_pipe_reg;
`else
  assign hs    = hs_reg;
  assign vs    = vs_reg;
  assign blank = blank_reg;
`endif

  assign pixel_clk   = pixel_clk_reg;
  assign pix_en      = pix_en_reg;
  assign frame_start = frame_start_reg;
  assign vblank      = vblank_reg;
  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen. A reduced raster keeps whole frames
// short. The reference model derives every output from the number of CLK
// edges since reset release using division/modulo arithmetic. Expected
// values are queued each cycle and on asynchronous reset assertion; a
// separate monitor pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_VISIBLE = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BP      = 3;
  localparam int V_VISIBLE = 8;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 3;
  localparam int CLK_DIV   = 4;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pixel_clk, pix_en, hs, vs, blank, sync, frame_start, vblank;
  logic [9:0] DrawX, DrawY;

  typedef struct packed {
    logic       pixel_clk;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       frame_start;
    logic       vblank;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   edges      = 0;
  int   cyc        = 0;
  int   last_fs    = -1;
  event chk_ev;

  always #5 CLK = ~CLK;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .pixel_clk(pixel_clk),
    .pix_en(pix_en),
    .hs(hs),
    .vs(vs),
    .blank(blank),
    .sync(sync),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .frame_start(frame_start),
    .vblank(vblank)
  );

  // Reference: n = CLK edges since reset release (0 while in reset).
  function automatic obs_t model(int n);
    obs_t e;
    int   p, x, y, q, qx, qy;
    logic dec_ok;
    p = n / CLK_DIV;
    x = p % H_TOTAL;
    y = (p / H_TOTAL) % V_TOTAL;
    e.pix_en      = (n > 0) && ((n % CLK_DIV) == 0);
    e.pixel_clk   = ((n % CLK_DIV) >= (CLK_DIV / 2));
    e.x           = 10'(x);
    e.y           = 10'(y);
    e.frame_start = e.pix_en && ((p % (H_TOTAL * V_TOTAL)) == 0);
    e.vblank      = (y >= V_VISIBLE);
    e.sync        = 1'b0;
`ifdef VGA_PIPE_ALIGN_EN
    q      = p - 1;
    dec_ok = (p >= 2);
`else
    q      = p;
    dec_ok = (p >= 1);
`endif
    if (q < 0) q = 0;
    qx = q % H_TOTAL;
    qy = (q / H_TOTAL) % V_TOTAL;
    e.hs    = dec_ok ? !((qx >= H_VISIBLE + H_FP) && (qx < H_VISIBLE + H_FP + H_SYNC)) : 1'b1;
    e.vs    = dec_ok ? !((qy >= V_VISIBLE + V_FP) && (qy < V_VISIBLE + V_FP + V_SYNC)) : 1'b1;
    e.blank = dec_ok ? ((qx < H_VISIBLE) && (qy < V_VISIBLE)) : 1'b0;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.pixel_clk   = pixel_clk;
    a.pix_en      = pix_en;
    a.hs          = hs;
    a.vs          = vs;
    a.blank       = blank;
    a.sync        = sync;
    a.frame_start = frame_start;
    a.vblank      = vblank;
    a.x           = DrawX;
    a.y           = DrawY;
    return a;
  endfunction

  // Edge counter for the model; cleared while reset is held.
  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Expectation producer: one entry per CLK, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      exp_q.push_back(Reset_n ? model(edges) : model(0));
      -> chk_ev;
    end
  end

  // Monitor: drains the queue and compares with what the DUT presents.
  initial begin
    obs_t e, a;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observe();
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL raster t=%0t got pclk/pen/hs/vs/blank/sync/fs/vblank=%b x=%0d y=%0d required %b x=%0d y=%0d",
                   $time, a[27:20], a.x, a.y, e[27:20], e.x, e.y);
        end
      end
      if (!Reset_n) begin
        last_fs = -1;
      end else if (frame_start) begin
        if (last_fs >= 0) begin
          compared++;
          if (cyc - last_fs != FRAME_CLK) begin
            mismatched++;
            $display("FAIL frame_period got %0d CLK required %0d CLK", cyc - last_fs, FRAME_CLK);
          end
        end
        last_fs = cyc;
      end
    end
  end

  // Asynchronous reset pulse starting mid-cycle; outputs are checked
  // before the next clock edge, then reset is held across one rising edge.
  task automatic pulse_reset();
    #1 Reset_n = 1'b0;
    #1 exp_q.push_back(model(0));
    -> chk_ev;
    @(posedge CLK);
    @(negedge CLK);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #1 Reset_n = 1'b1;

    // Several full frames from a clean release.
    repeat (2 * FRAME_CLK + 37) @(posedge CLK);

    // Directed mid-frame reset at pixel (10,5) of a fresh frame.
    pulse_reset();
    repeat ((5 * H_TOTAL + 10) * CLK_DIV) @(posedge CLK);
    pulse_reset();

    // Randomly placed reset pulses.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(10, FRAME_CLK)) @(posedge CLK);
      pulse_reset();
    end

    repeat (2 * FRAME_CLK + 20) @(posedge CLK);
    @(negedge CLK);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
